serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 118 +++++++++++
 tb/tb_serial_subtractor.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default operand width.
// No logic; imported by the datapath files.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, combinational (zero latency).
// No flow control; pure function of its inputs.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first; done pulses WIDTH cycles after the accepting edge.
// start is only sampled in IDLE; one operation per WIDTH+2 cycles, requests while busy are dropped.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] a_shifted;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // The minuend register doubles as the result accumulator: each consumed
    // LSB is replaced by a difference bit entering at the top.
    always_comb begin
        a_shifted            = a_q >> 1;
        a_shifted[WIDTH-1]   = fs_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_shifted;
                b_d   = b_q >> 1;
                br_d  = fs_bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    diff_d  = a_shifted;
                    bout_d  = fs_bout;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Diff = diff_q;
    assign Bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: hand-computed vectors, mid-run start/reset, full operand sweep.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       Bin;
    logic [3:0] Diff;
    logic       Bout;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_pass = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .Diff  (Diff),
        .Bout  (Bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Step negedges until done is seen (bounded); reports cycles taken and busy cycles seen.
    task automatic wait_done(input string tag, output int lat, output int nbusy);
        bit seen;
        seen  = 0;
        lat   = 0;
        nbusy = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
            if (done) seen = 1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic bi, input logic [3:0] exp_d, input logic exp_b);
        int lat, nbusy;
        A = a; B = b; Bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = ~a; B = ~b; Bin = ~bi;
        if (busy) nbusy = 1; else nbusy = 0;
        chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        wait_done(tag, lat, nbusy);
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd3);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        chk({tag, "_diff"}, 32'(Diff), 32'(exp_d));
        chk({tag, "_bout"}, 32'(Bout), 32'(exp_b));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_diff_hold"}, 32'(Diff), 32'(exp_d));
    endtask

    initial begin
        int lat, nbusy, ndone;
        int ea, eb, ebi, ed, ebo;

        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_diff", 32'(Diff), 32'd0);
        chk("reset_bout", 32'(Bout), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        run_op("v5m3",  4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0);
        run_op("v3m5",  4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1);
        run_op("v0m0b", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1);
        run_op("vFmFb", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);

        // A second start (with new operands) during SHIFT must be ignored.
        @(negedge clk);
        A = 4'b1000; B = 4'b0001; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 4'b0000; B = 4'b1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", lat, nbusy);
        chk("ignore_diff", 32'(Diff), 32'b0111);
        chk("ignore_bout", 32'(Bout), 32'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("ignore_no_second_done", 32'(ndone), 32'd0);
        chk("ignore_diff_hold", 32'(Diff), 32'b0111);

        // Reset on the second SHIFT cycle aborts the operation.
        A = 4'b0101; B = 4'b0011; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_diff", 32'(Diff), 32'd0);
        chk("abort_bout", 32'(Bout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // Reset wins over start at the same edge.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rst_prio_busy_2", 32'(busy), 32'd0);

        // Sweep of every (A, B, Bin) with start held high; 6-cycle done spacing.
        A = 4'd0; B = 4'd0; Bin = 1'b0; start = 1'b1;
        for (int k = 0; k < 512; k++) begin
            ea  = k[8:5];
            eb  = k[4:1];
            ebi = k[0];
            ed  = (ea - eb - ebi) & 15;
            ebo = (ea < eb + ebi) ? 1 : 0;
            wait_done($sformatf("sweep_%0d", k), lat, nbusy);
            chk($sformatf("sweep_%0d_result", k), {27'd0, Bout, Diff}, 32'((ebo << 4) | ed));
            chk($sformatf("sweep_%0d_spacing", k), 32'(lat), (k == 0) ? 32'd5 : 32'd6);
            if (k < 511) begin
                A   = 4'((k + 1) >> 5);
                B   = 4'(((k + 1) >> 1) & 15);
                Bin = 1'((k + 1) & 1);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
